// File: rtl/ipq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ipq_pkg                                                |
// | Description : Shared types and sizing for the instruction prefetch   |
// |               queue (fetch FSM states, queue entry layout).          |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package ipq_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int PTR_W     = $clog2(DEPTH_DEF);
    localparam int PC_W_DEF  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DROP = 2'd2
    } ipq_state_e;

    // Queue entries are stored packed as {pc, inst}, matching this layout.
    typedef struct packed {
        logic [PC_W_DEF-1:0] pc;
        logic [PC_W_DEF-1:0] inst;
    } ipq_entry_t;

endpackage
`default_nettype wire

// File: rtl/ipq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ipq_fifo                                               |
// | Description : Synchronous FIFO with push/pop/flush and occupancy     |
// |               count; flush overrides push and pop.                   |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module ipq_fifo
    import ipq_pkg::*;
#(
    parameter int DEPTH = (1 << PTR_W),
    parameter int WIDTH = 2 * PC_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q,  w_count_d;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (i_push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
            if (i_pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
            case ({i_push, i_pop})
                2'b10:   w_count_d = r_count_q + 1'b1;
                2'b01:   w_count_d = r_count_q - 1'b1;
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Storage needs no reset: the count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem_q[r_wr_ptr_q] <= i_wdata;
    end

    assign o_rdata = r_mem_q[r_rd_ptr_q];
    assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : inst_prefetch_queue                                    |
// | Description : Fetch front end: issues word requests to instruction  |
// |               memory, queues {pc, inst} and feeds IF/ID; redirects   |
// |               flush the queue and cancel the in-flight response.     |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module inst_prefetch_queue
    import ipq_pkg::*;
#(
    parameter int              DEPTH    = DEPTH_DEF,
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [PC_W-1:0] mem_rdata,
    output logic            deq_valid,
    input  logic            deq_ready,
    output logic [PC_W-1:0] deq_inst,
    output logic [PC_W-1:0] deq_pc,
    output logic [PC_W-1:0] deq_pc_plus1,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            busy_drop
);

    localparam int                 c_CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH_M1 = c_CNT_W'(DEPTH - 1);

    ipq_state_e          r_state_q,    w_state_d;
    logic [PC_W-1:0]     r_fetch_pc_q, w_fetch_pc_d;
    logic [PC_W-1:0]     r_req_addr_q, w_req_addr_d;

    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W-1:0]  w_count_next;
    logic                w_pop;
    logic                w_push;
    logic [2*PC_W-1:0]   w_head;

    assign w_pop        = deq_valid && deq_ready && !redirect;
    assign w_count_next = w_count - {{(c_CNT_W-1){1'b0}}, w_pop};

    // A request is only issued when its slot is free after this cycle's pop,
    // so every accepted response is guaranteed room in the queue.
    always_comb begin
        w_state_d    = r_state_q;
        w_fetch_pc_d = r_fetch_pc_q;
        w_req_addr_d = r_req_addr_q;
        w_push       = 1'b0;
        case (r_state_q)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_d = redirect_pc;
                end else if (w_count_next < c_DEPTH) begin
                    w_req_addr_d = r_fetch_pc_q;
                    w_fetch_pc_d = r_fetch_pc_q + 1'b1;
                    w_state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    if (redirect) begin
                        w_fetch_pc_d = redirect_pc;
                        w_state_d    = S_IDLE;
                    end else begin
                        w_push = 1'b1;
                        if (w_count_next < c_DEPTH_M1) begin
                            w_req_addr_d = r_fetch_pc_q;
                            w_fetch_pc_d = r_fetch_pc_q + 1'b1;
                        end else begin
                            w_state_d = S_IDLE;
                        end
                    end
                end else if (redirect) begin
                    w_fetch_pc_d = redirect_pc;
                    w_state_d    = S_DROP;
                end
            end
            S_DROP: begin
                if (redirect) w_fetch_pc_d = redirect_pc;
                if (mem_ack)  w_state_d    = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_fetch_pc_q <= RESET_PC;
            r_req_addr_q <= RESET_PC;
        end else begin
            r_state_q    <= w_state_d;
            r_fetch_pc_q <= w_fetch_pc_d;
            r_req_addr_q <= w_req_addr_d;
        end
    end

    ipq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * PC_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata ({r_req_addr_q, mem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count)
    );

    assign mem_req      = (r_state_q == S_BUSY) || (r_state_q == S_DROP);
    assign mem_addr     = r_req_addr_q;
    assign busy_drop    = (r_state_q == S_DROP);
    assign deq_valid    = (w_count != '0);
    assign deq_pc       = w_head[2*PC_W-1:PC_W];
    assign deq_inst     = w_head[PC_W-1:0];
    assign deq_pc_plus1 = deq_pc + 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_inst_prefetch_queue                                 |
// | Description : Directed bench: per-cycle vector table plus redirect,  |
// |               wrap-around and reset sequences against a memory model.|
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_inst_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        deq_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    logic        mem_req,   mem_ack;
    logic [31:0] mem_addr,  mem_rdata;
    logic        deq_valid, busy_drop;
    logic [31:0] deq_inst,  deq_pc, deq_pc_plus1;

    logic        mem_req_w,   mem_ack_w;
    logic [31:0] mem_addr_w,  mem_rdata_w;
    logic        deq_valid_w, busy_drop_w;
    logic [31:0] deq_inst_w,  deq_pc_w, deq_pc_plus1_w;

    int errs   = 0;
    int checks = 0;
    int lat    = 1;

    initial forever #5 clk = ~clk;

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'd0), .PC_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst),
        .deq_pc(deq_pc), .deq_pc_plus1(deq_pc_plus1),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy_drop(busy_drop)
    );

    inst_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFE), .PC_W(32)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
        .deq_valid(deq_valid_w), .deq_ready(deq_ready), .deq_inst(deq_inst_w),
        .deq_pc(deq_pc_w), .deq_pc_plus1(deq_pc_plus1_w),
        .redirect(redirect), .redirect_pc(redirect_pc), .busy_drop(busy_drop_w)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: acks in the lat-th cycle of each request, data derived from address.
    initial begin
        int w;
        w = 0; mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!mem_req) begin
                w = 0; mem_ack = 1'b0;
            end else begin
                if (mem_ack) w = 0;
                w++;
                mem_ack   = (w == lat);
                mem_rdata = inst_of(mem_addr);
            end
        end
    end

    initial begin
        int w;
        w = 0; mem_ack_w = 1'b0; mem_rdata_w = '0;
        forever begin
            @(posedge clk); #1;
            if (!mem_req_w) begin
                w = 0; mem_ack_w = 1'b0;
            end else begin
                if (mem_ack_w) w = 0;
                w++;
                mem_ack_w   = (w == lat);
                mem_rdata_w = inst_of(mem_addr_w);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs just after the edge, return at the falling edge.
    task automatic cyc(input bit r, input bit rdy, input bit rd, input logic [31:0] rpc);
        @(posedge clk); #1;
        rst = r; deq_ready = rdy; redirect = rd; redirect_pc = rpc;
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          req;
        logic [31:0] addr;
        bit          vld;
        logic [31:0] pc;
        bit          drop;
    } vec_t;

    function automatic vec_t v(input bit r, input bit rdy, input bit req,
                               input logic [31:0] addr, input bit vld,
                               input logic [31:0] pc, input bit drop);
        vec_t t;
        t.rst = r; t.rdy = rdy; t.req = req; t.addr = addr;
        t.vld = vld; t.pc = pc; t.drop = drop;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        int   n;

        rst = 1'b1; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // Back-to-back fetch with 1-cycle memory and no stalls
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 2, 1, 1, 0));
        tbl.push_back(v(0, 1, 1, 3, 1, 2, 0));
        tbl.push_back(v(0, 1, 1, 4, 1, 3, 0));
        // Ten-cycle stall: queue fills, requests stop, then drains in order
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 2, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 3, 1, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 4, 1, 1, 0));
        tbl.push_back(v(0, 1, 1, 5, 1, 2, 0));
        tbl.push_back(v(0, 1, 1, 6, 1, 3, 0));
        tbl.push_back(v(0, 1, 1, 7, 1, 4, 0));

        lat = 1;
        n = tbl.size();
        for (int i = 0; i < n; i++) begin
            cyc(tbl[i].rst, tbl[i].rdy, 1'b0, '0);
            if (!tbl[i].rst) begin
                chk($sformatf("row%0d mem_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
                if (tbl[i].req)
                    chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].addr);
                chk($sformatf("row%0d deq_valid", i), {31'd0, deq_valid}, {31'd0, tbl[i].vld});
                if (tbl[i].vld) begin
                    chk($sformatf("row%0d deq_pc", i), deq_pc, tbl[i].pc);
                    chk($sformatf("row%0d deq_pc_plus1", i), deq_pc_plus1, tbl[i].pc + 32'd1);
                    chk($sformatf("row%0d deq_inst", i), deq_inst, inst_of(tbl[i].pc));
                end
                chk($sformatf("row%0d busy_drop", i), {31'd0, busy_drop}, {31'd0, tbl[i].drop});
            end
        end

        // Redirect mid-request with 3-cycle memory: response for addr 2 is dropped
        lat = 3;
        cyc(1'b1, 1'b1, 1'b0, '0);
        for (int c = 0; c <= 14; c++) begin
            cyc(1'b0, 1'b1, (c == 8), 32'h40);
            if (c == 8) begin
                chk("drop_pre addr", mem_addr, 32'd2);
                chk("drop_pre busy_drop", {31'd0, busy_drop}, 32'd0);
            end
            if (c == 9) begin
                chk("drop busy_drop", {31'd0, busy_drop}, 32'd1);
                chk("drop mem_req", {31'd0, mem_req}, 32'd1);
            end
            if (c >= 8 && c <= 13)
                chk($sformatf("drop c%0d deq_valid", c), {31'd0, deq_valid}, 32'd0);
            if (c == 10) begin
                chk("drop idle mem_req", {31'd0, mem_req}, 32'd0);
                chk("drop idle busy_drop", {31'd0, busy_drop}, 32'd0);
            end
            if (c == 11) begin
                chk("redir mem_req", {31'd0, mem_req}, 32'd1);
                chk("redir mem_addr", mem_addr, 32'h40);
            end
            if (c == 14) begin
                chk("redir deq_valid", {31'd0, deq_valid}, 32'd1);
                chk("redir deq_pc", deq_pc, 32'h40);
                chk("redir deq_inst", deq_inst, inst_of(32'h40));
            end
        end

        // Redirect coinciding with ack and a would-be pop
        lat = 1;
        cyc(1'b1, 1'b1, 1'b0, '0);
        for (int c = 0; c <= 5; c++) begin
            cyc(1'b0, 1'b1, (c == 2), 32'h80);
            if (c == 2) begin
                chk("ackredir pre deq_pc", deq_pc, 32'd0);
                chk("ackredir pre mem_ack", {31'd0, mem_ack}, 32'd1);
            end
            if (c == 3) begin
                chk("ackredir deq_valid", {31'd0, deq_valid}, 32'd0);
                chk("ackredir mem_req", {31'd0, mem_req}, 32'd0);
            end
            if (c == 4) begin
                chk("ackredir mem_addr", mem_addr, 32'h80);
                chk("ackredir req", {31'd0, mem_req}, 32'd1);
                chk("ackredir empty", {31'd0, deq_valid}, 32'd0);
            end
            if (c == 5) begin
                chk("ackredir deq_pc", deq_pc, 32'h80);
                chk("ackredir deq_inst", deq_inst, inst_of(32'h80));
            end
        end

        // Address wrap from RESET_PC = FFFFFFFE
        cyc(1'b1, 1'b1, 1'b0, '0);
        for (int c = 0; c <= 4; c++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            if (c == 1) chk("wrap addr0", mem_addr_w, 32'hFFFF_FFFE);
            if (c == 2) begin
                chk("wrap addr1", mem_addr_w, 32'hFFFF_FFFF);
                chk("wrap pc0", deq_pc_w, 32'hFFFF_FFFE);
                chk("wrap pc0+1", deq_pc_plus1_w, 32'hFFFF_FFFF);
            end
            if (c == 3) begin
                chk("wrap addr2", mem_addr_w, 32'd0);
                chk("wrap pc1", deq_pc_w, 32'hFFFF_FFFF);
                chk("wrap pc1+1", deq_pc_plus1_w, 32'd0);
                chk("wrap inst1", deq_inst_w, inst_of(32'hFFFF_FFFF));
            end
            if (c == 4) chk("wrap pc2", deq_pc_w, 32'd0);
        end

        // Reset while busy with two entries queued
        cyc(1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c <= 2; c++) cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("midrst pre mem_req", {31'd0, mem_req}, 32'd1);
        chk("midrst pre mem_addr", mem_addr, 32'd2);
        chk("midrst pre deq_valid", {31'd0, deq_valid}, 32'd1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst deq_valid", {31'd0, deq_valid}, 32'd0);
        chk("midrst busy_drop", {31'd0, busy_drop}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("midrst restart req", {31'd0, mem_req}, 32'd1);
        chk("midrst restart addr", mem_addr, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("midrst restart deq_pc", deq_pc, 32'd0);
        chk("midrst restart valid", {31'd0, deq_valid}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
